// File: rtl/entry_alloc_ctrl.sv
// Dual-lane entry allocator: busy bitmap, two lowest-free grants per cycle,
// up to two releases per cycle, flush, and a registered free count with full/empty status.
module entry_alloc_ctrl #(
  parameter int unsigned N_ENTRY = 16,
  parameter int unsigned IDX_W   = $clog2(N_ENTRY),
  parameter int unsigned CNT_W   = $clog2(N_ENTRY + 1)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [1:0]       i_alloc_req,
  output logic [1:0]       o_alloc_gnt,
  output logic [IDX_W-1:0] o_alloc_idx0,
  output logic [IDX_W-1:0] o_alloc_idx1,
  input  logic [1:0]       i_free_vld,
  input  logic [IDX_W-1:0] i_free_idx0,
  input  logic [IDX_W-1:0] i_free_idx1,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_free_cnt,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(N_ENTRY);

  logic [N_ENTRY-1:0] r_busy;
  logic [CNT_W-1:0]   r_free_cnt;
  logic               r_full;
  logic               r_empty;

  logic [N_ENTRY-1:0] w_free;
  logic [N_ENTRY-1:0] w_free_rest;
  logic [IDX_W-1:0]   w_c1;
  logic [IDX_W-1:0]   w_c2;
  logic               w_c1_vld;
  logic               w_c2_vld;
  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_idx0_ok;
  logic               w_idx1_ok;
  logic [N_ENTRY-1:0] w_gnt_oh;
  logic [N_ENTRY-1:0] w_rel_req_oh;
  logic [N_ENTRY-1:0] w_rel_oh;
  logic [N_ENTRY-1:0] w_busy_next;
  logic [CNT_W-1:0]   w_gnt_cnt;
  logic [CNT_W-1:0]   w_rel_cnt;
  logic [CNT_W:0]     w_cnt_wide;
  logic [CNT_W-1:0]   w_cnt_next;

  function automatic logic [CNT_W-1:0] popcnt(input logic [N_ENTRY-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(N_ENTRY); i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  assign w_free = ~r_busy;

  // Lowest and next-lowest free entries (find_two_set_bits on ~busy).
  always_comb begin
    w_c1        = '0;
    w_c1_vld    = 1'b0;
    w_c2        = '0;
    w_c2_vld    = 1'b0;
    w_free_rest = w_free;
    for (int i = 0; i < int'(N_ENTRY); i++) begin
      if (w_free[i] && !w_c1_vld) begin
        w_c1        = IDX_W'(i);
        w_c1_vld    = 1'b1;
        w_free_rest = w_free & ~(N_ENTRY'(1) << i);
      end
    end
    for (int i = 0; i < int'(N_ENTRY); i++) begin
      if (w_free_rest[i] && !w_c2_vld) begin
        w_c2     = IDX_W'(i);
        w_c2_vld = 1'b1;
      end
    end
  end

  // Grants see only registered busy, so same-cycle releases are never re-granted.
  assign w_gnt0 = !i_reset && !i_flush && i_alloc_req[0] && w_c1_vld;
  assign w_gnt1 = !i_reset && !i_flush && (i_alloc_req == 2'b11) && w_c2_vld;

  assign o_alloc_gnt  = {w_gnt1, w_gnt0};
  assign o_alloc_idx0 = w_gnt0 ? w_c1 : '0;
  assign o_alloc_idx1 = w_gnt1 ? w_c2 : '0;

  assign w_idx0_ok = 32'(i_free_idx0) < N_ENTRY;
  assign w_idx1_ok = 32'(i_free_idx1) < N_ENTRY;

  always_comb begin
    w_gnt_oh = '0;
    if (w_gnt0) w_gnt_oh = w_gnt_oh | (N_ENTRY'(1) << w_c1);
    if (w_gnt1) w_gnt_oh = w_gnt_oh | (N_ENTRY'(1) << w_c2);
    w_rel_req_oh = '0;
    if (i_free_vld[0] && w_idx0_ok) w_rel_req_oh = w_rel_req_oh | (N_ENTRY'(1) << i_free_idx0);
    if (i_free_vld[1] && w_idx1_ok) w_rel_req_oh = w_rel_req_oh | (N_ENTRY'(1) << i_free_idx1);
  end

  // Masking with busy drops bogus frees; the OR merge counts a duplicate release once.
  assign w_rel_oh    = w_rel_req_oh & r_busy;
  assign w_busy_next = (r_busy | w_gnt_oh) & ~w_rel_oh;
  assign w_gnt_cnt   = CNT_W'(w_gnt0) + CNT_W'(w_gnt1);
  assign w_rel_cnt   = popcnt(w_rel_oh);
  assign w_cnt_wide  = {1'b0, r_free_cnt} - {1'b0, w_gnt_cnt} + {1'b0, w_rel_cnt};
  assign w_cnt_next  = w_cnt_wide[CNT_W-1:0];

  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      r_busy     <= '0;
      r_free_cnt <= FullCnt;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
    end else begin
      r_busy     <= w_busy_next;
      r_free_cnt <= w_cnt_next;
      r_full     <= (w_cnt_next == '0);
      r_empty    <= (w_cnt_next == FullCnt);
    end
  end

  assign o_free_cnt = r_free_cnt;
  assign o_full     = r_full;
  assign o_empty    = r_empty;

  // Protocol misuse is reported but tolerated; count drift is a design bug.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      assert (r_free_cnt == popcnt(w_free))
        else $error("free_cnt %0d disagrees with busy map", r_free_cnt);
      assert (i_alloc_req != 2'b10)
        else $warning("non-contiguous alloc_req");
      if (!i_flush) begin
        assert (!(i_free_vld == 2'b11 && i_free_idx0 == i_free_idx1))
          else $warning("duplicate release of entry %0d", i_free_idx0);
        assert (!(i_free_vld[0] && (!w_idx0_ok || !r_busy[i_free_idx0])))
          else $warning("lane0 release of idle entry %0d", i_free_idx0);
        assert (!(i_free_vld[1] && (!w_idx1_ok || !r_busy[i_free_idx1])))
          else $warning("lane1 release of idle entry %0d", i_free_idx1);
      end
    end
  end

endmodule

// File: tb/tb_entry_alloc_ctrl.sv
// Scoreboard bench for entry_alloc_ctrl: directed vectors then a long randomized run
// checked against a behavioural busy-map model.
module tb_entry_alloc_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [3:0] idx0;
  logic [3:0] idx1;
  logic [1:0] fv;
  logic [3:0] fi0;
  logic [3:0] fi1;
  logic       fl;
  logic [4:0] cnt;
  logic       full;
  logic       empty;

  typedef struct {
    logic [1:0] gnt;
    logic [3:0] i0;
    logic [3:0] i1;
    logic [4:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  entry_alloc_ctrl #(.N_ENTRY(16)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_alloc_req (req),
    .o_alloc_gnt (gnt),
    .o_alloc_idx0(idx0),
    .o_alloc_idx1(idx1),
    .i_free_vld  (fv),
    .i_free_idx0 (fi0),
    .i_free_idx1 (fi1),
    .i_flush     (fl),
    .o_free_cnt  (cnt),
    .o_full      (full),
    .o_empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("gnt", int'(gnt), int'(e.gnt));
      chk("idx0", int'(idx0), int'(e.i0));
      chk("idx1", int'(idx1), int'(e.i1));
      chk("free_cnt", int'(cnt), int'(e.cnt));
      chk("full", int'(full), int'(e.cnt == 5'd0));
      chk("empty", int'(empty), int'(e.cnt == 5'd16));
    end
  end

  // Drive one cycle of inputs and queue the response expected during that cycle.
  task automatic step(input logic r, input logic [1:0] rq, input logic [1:0] v,
                      input logic [3:0] f0, input logic [3:0] f1, input logic f,
                      input logic [1:0] eg, input logic [3:0] e0, input logic [3:0] e1,
                      input logic [4:0] ec);
    exp_t e;
    rst = r; req = rq; fv = v; fi0 = f0; fi1 = f1; fl = f;
    e.gnt = eg; e.i0 = e0; e.i1 = e1; e.cnt = ec;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] ec);
    step(1'b0, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0, 2'b00, 4'd0, 4'd0, ec);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] mb;
  logic [15:0] mfree;
  logic [1:0]  r_rq;
  logic [1:0]  r_v;
  logic [3:0]  r_f0;
  logic [3:0]  r_f1;
  logic        r_fl;
  logic [1:0]  eg;
  logic [3:0]  c1;
  logic [3:0]  c2;
  int          nfree;
  int          found;

  initial begin
    rst = 1'b1; req = 2'b11; fv = 2'b00; fi0 = '0; fi1 = '0; fl = 1'b0;
    @(posedge clk);
    #1;
    // Reset cycle: request ignored, status at reset values.
    step(1'b1, 2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 2'b00, 4'd0, 4'd0, 5'd16);

    // Test 1: fill in pairs.
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 2'b11, 4'(2 * k), 4'(2 * k + 1),
           5'(16 - 2 * k));
    end
    step(1'b0, 2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 2'b00, 4'd0, 4'd0, 5'd0);

    // Test 2: freed entry not grantable same cycle, grantable next.
    step(1'b0, 2'b11, 2'b01, 4'd5, 4'd0, 1'b0, 2'b00, 4'd0, 4'd0, 5'd0);
    step(1'b0, 2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 2'b01, 4'd5, 4'd0, 5'd1);
    idle(5'd0);

    // Test 3: only 3 and 9 free.
    step(1'b0, 2'b00, 2'b11, 4'd3, 4'd9, 1'b0, 2'b00, 4'd0, 4'd0, 5'd0);
    step(1'b0, 2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 2'b11, 4'd3, 4'd9, 5'd2);
    idle(5'd0);

    // Test 4: flush with 10 busy overrides grants and frees.
    step(1'b0, 2'b00, 2'b00, 4'd0, 4'd0, 1'b1, 2'b00, 4'd0, 4'd0, 5'd0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 2'b11, 4'(2 * k), 4'(2 * k + 1),
           5'(16 - 2 * k));
    end
    step(1'b0, 2'b11, 2'b11, 4'd1, 4'd2, 1'b1, 2'b00, 4'd0, 4'd0, 5'd6);
    step(1'b0, 2'b01, 2'b00, 4'd0, 4'd0, 1'b0, 2'b01, 4'd0, 4'd0, 5'd16);
    idle(5'd15);

    // Test 5: busy 0..8, duplicate free of 7, then free of idle entry 12.
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 2'b11, 4'(2 * k + 1), 4'(2 * k + 2),
           5'(15 - 2 * k));
    end
    step(1'b0, 2'b00, 2'b11, 4'd7, 4'd7, 1'b0, 2'b00, 4'd0, 4'd0, 5'd7);
    step(1'b0, 2'b00, 2'b01, 4'd12, 4'd0, 1'b0, 2'b00, 4'd0, 4'd0, 5'd8);
    idle(5'd8);
    step(1'b0, 2'b01, 2'b00, 4'd0, 4'd0, 1'b0, 2'b01, 4'd7, 4'd0, 5'd8);
    // Non-contiguous request grants nothing.
    step(1'b0, 2'b10, 2'b00, 4'd0, 4'd0, 1'b0, 2'b00, 4'd0, 4'd0, 5'd7);
    step(1'b0, 2'b00, 2'b00, 4'd0, 4'd0, 1'b1, 2'b00, 4'd0, 4'd0, 5'd7);

    // Test 6: randomized traffic against a busy-map model.
    mb = '0;
    for (int n = 0; n < 10000; n++) begin
      case ($urandom_range(0, 3))
        0:       r_rq = 2'b00;
        1:       r_rq = 2'b01;
        default: r_rq = 2'b11;
      endcase
      r_v  = 2'($urandom_range(0, 3));
      r_f0 = 4'($urandom_range(0, 15));
      r_f1 = 4'($urandom_range(0, 15));
      r_fl = ($urandom_range(0, 63) == 0);
      mfree = ~mb;
      nfree = 0;
      found = 0;
      c1 = '0;
      c2 = '0;
      for (int i = 0; i < 16; i++) begin
        if (mfree[i]) begin
          nfree++;
          if (found == 0) c1 = 4'(i);
          else if (found == 1) c2 = 4'(i);
          found++;
        end
      end
      eg = 2'b00;
      if (!r_fl && r_rq[0] && nfree >= 1) eg[0] = 1'b1;
      if (!r_fl && r_rq == 2'b11 && nfree >= 2) eg[1] = 1'b1;
      step(1'b0, r_rq, r_v, r_f0, r_f1, r_fl, eg, eg[0] ? c1 : 4'd0, eg[1] ? c2 : 4'd0,
           5'(nfree));
      if (r_fl) begin
        mb = '0;
      end else begin
        if (eg[0]) mb[c1] = 1'b1;
        if (eg[1]) mb[c2] = 1'b1;
        if (r_v[0] && !mfree[r_f0]) mb[r_f0] = 1'b0;
        if (r_v[1] && !mfree[r_f1]) mb[r_f1] = 1'b0;
      end
    end

    req = 2'b00; fv = 2'b00; fl = 1'b0;
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
